mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer that lets up to four requesters share the single MUX instruction port. It sits between the requesters and the MUX: the instruction-fetch unit is requester 0, and host direct-access or calibration engines are requesters 1 to 3. For each granted request it issues one 24-bit MUX instruction, tracks the MUX until it returns to idle, and routes any MUX read data back to the requester that owns the current operation.

---
 rtl/mux_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mux_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// ---------------------------------------------------------------------------
// mux_arbiter
//   Round-robin arbiter / sequencer sharing the single MUX instruction port
//   among N_REQ requesters (0 = instruction fetch, 1..3 = host/calibration).
//   One 24-bit instruction is issued per grant. The MUX is tracked through
//   ISSUE -> GUARD -> WAIT until it reports idle. Read data is routed back to
//   the owner of the current operation.
//
// Parameters
//   N_REQ          number of requesters, 2..4
//   GUARD_CYCLES   cycles after issue during which mux_idle_i is ignored, 1..255
//   TIMEOUT_CYCLES WAIT watchdog limit, 16..65535 (MUX_ARB_TIMEOUT_EN only)
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN (watchdog on WAIT; when it is
//   undefined no counter is built and timeout_o is tied low).
//
// Ports
//   fpga_clk_i        clock, rising edge
//   reset_n_i         synchronous reset, active low
//   req_valid_i       per-requester pending flag, held until ack
//   req_ins_i         per-requester instruction, requester k at [24k+23:24k]
//   req_ack_o         one-cycle pulse: request k issued
//   resp_valid_o      one-cycle pulse: resp_data_o belongs to requester k
//   resp_data_o       shared response data
//   grant_id_o        current / last owner
//   busy_o            high in every state except IDLE
//   timeout_o         one-cycle watchdog pulse
//   mux_ins_o         instruction to the MUX
//   mux_en_o          one-cycle start strobe to the MUX
//   mux_idle_i        MUX idle
//   mux_data_ready_i  mux_data_i valid this cycle
//   mux_data_i        MUX read data
// ---------------------------------------------------------------------------

// Per-requester output flops: ack and response-valid strobes.
module mux_arbiter_lane (
  input  logic fpga_clk_i,
  input  logic reset_n_i,
  input  logic ack_set,
  input  logic resp_set,
  output logic ack,
  output logic resp_valid
);
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      ack        <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      ack        <= ack_set;
      resp_valid <= resp_set;
    end
  end
endmodule

module mux_arbiter #(
  parameter int N_REQ          = 2,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [24*N_REQ-1:0]   req_ins_i,
  output logic [N_REQ-1:0]      req_ack_o,
  output logic [N_REQ-1:0]      resp_valid_o,
  output logic [15:0]           resp_data_o,
  output logic [1:0]            grant_id_o,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [23:0]           mux_ins_o,
  output logic                  mux_en_o,
  input  logic                  mux_idle_i,
  input  logic                  mux_data_ready_i,
  input  logic [15:0]           mux_data_i
);

  // Elaboration-time parameter range checks.
  if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
    $error("mux_arbiter: N_REQ out of range 2..4");
  end
  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard
    $error("mux_arbiter: GUARD_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("mux_arbiter: TIMEOUT_CYCLES out of range 16..65535");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        last;
  logic [7:0]        guard_cnt;
  logic [3:0]        req_pad;
  logic [3:0][23:0]  ins_pad;
  logic              win_found;
  logic [1:0]        win_idx;
  logic [2:0]        cand;
  logic              issue;
  logic              resp_take;
  logic              tmo_hit;

  // Widen requester vectors to four slots so a 2-bit index always fits.
  always_comb begin
    req_pad = '0;
    ins_pad = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_pad[i] = req_valid_i[i];
      ins_pad[i] = req_ins_i[24*i +: 24];
    end
  end

  // Round-robin search starting after the last winner. last < N_REQ and
  // i <= N_REQ, so one conditional subtraction is a full modulo.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = 3'(last) + 3'(i);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (!win_found && req_pad[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  // FSM state register
  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mux_idle_i && win_found) begin
          state_nxt = S_ISSUE;
          issue     = 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_GUARD;
      S_GUARD: if (guard_cnt == 8'd0) state_nxt = S_WAIT;
      S_WAIT:  if (mux_idle_i || tmo_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data arriving on the WAIT->IDLE edge is still taken: state is WAIT
  // during that cycle and the owner is held in grant_id_o.
  assign resp_take = (state != S_IDLE) && mux_data_ready_i;
  assign busy_o    = (state != S_IDLE);

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      last        <= 2'(N_REQ - 1);
      mux_ins_o   <= '0;
      mux_en_o    <= 1'b0;
      grant_id_o  <= '0;
      resp_data_o <= '0;
      guard_cnt   <= '0;
    end else begin
      mux_en_o <= issue;
      if (issue) begin
        mux_ins_o  <= ins_pad[win_idx];
        grant_id_o <= win_idx;
        last       <= win_idx;
      end
      // Load on the ISSUE->GUARD edge so GUARD lasts GUARD_CYCLES cycles.
      if (state == S_ISSUE)
        guard_cnt <= 8'(GUARD_CYCLES - 1);
      else if (state == S_GUARD && guard_cnt != 8'd0)
        guard_cnt <= guard_cnt - 8'd1;
      if (resp_take) resp_data_o <= mux_data_i;
    end
  end

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    mux_arbiter_lane u_lane (
      .fpga_clk_i (fpga_clk_i),
      .reset_n_i  (reset_n_i),
      .ack_set    (issue && (win_idx == 2'(k))),
      .resp_set   (resp_take && (grant_id_o == 2'(k))),
      .ack        (req_ack_o[k]),
      .resp_valid (resp_valid_o[k])
    );
  end

`ifdef MUX_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Abandon WAIT when the MUX never comes back; no response is produced.
  assign tmo_hit = (state == S_WAIT) && !mux_idle_i &&
                   (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_n_i) begin
      tmo_cnt   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= tmo_hit;
      if (issue)
        tmo_cnt <= '0;
      else if (state == S_GUARD || state == S_WAIT)
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;
  localparam int N_REQ = 2;
  localparam int GUARD = 3;
  localparam int TMO   = 16;

  logic               fpga_clk_i = 1'b0;
  logic               reset_n_i;
  logic [N_REQ-1:0]   req_valid_i;
  logic [23:0]        ins0, ins1;
  logic [24*N_REQ-1:0] req_ins_i;
  logic [N_REQ-1:0]   req_ack_o;
  logic [N_REQ-1:0]   resp_valid_o;
  logic [15:0]        resp_data_o;
  logic [1:0]         grant_id_o;
  logic               busy_o;
  logic               timeout_o;
  logic [23:0]        mux_ins_o;
  logic               mux_en_o;
  logic               mux_idle_i;
  logic               mux_data_ready_i;
  logic [15:0]        mux_data_i;

  always #5 fpga_clk_i = ~fpga_clk_i;
  assign req_ins_i = {ins1, ins0};

  // MUX model: goes busy for 3 cycles after each start strobe.
  logic use_model, idle_drv;
  int   model_cnt = 0;
  always @(posedge fpga_clk_i) begin
    if (mux_en_o)           model_cnt <= 3;
    else if (model_cnt > 0) model_cnt <= model_cnt - 1;
  end
  assign mux_idle_i = use_model ? (model_cnt == 0) : idle_drv;

  mux_arbiter #(.N_REQ(N_REQ), .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO)) dut (
    .fpga_clk_i       (fpga_clk_i),
    .reset_n_i        (reset_n_i),
    .req_valid_i      (req_valid_i),
    .req_ins_i        (req_ins_i),
    .req_ack_o        (req_ack_o),
    .resp_valid_o     (resp_valid_o),
    .resp_data_o      (resp_data_o),
    .grant_id_o       (grant_id_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .mux_ins_o        (mux_ins_o),
    .mux_en_o         (mux_en_o),
    .mux_idle_i       (mux_idle_i),
    .mux_data_ready_i (mux_data_ready_i),
    .mux_data_i       (mux_data_i)
  );

  typedef struct packed { logic [1:0] g; logic [23:0] ins; } issue_t;
  typedef struct packed { logic [1:0] v; logic [15:0] d; }   resp_t;
  issue_t issue_q[$];
  resp_t  resp_q[$];
  issue_t mon_iss;
  resp_t  mon_rsp;

  int   errors = 0, checks = 0, issues_seen = 0, tmo_seen = 0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fpga_clk_i);
    #1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ins"},   32'(mux_ins_o),    32'd0);
    chk({p, "_en"},    32'(mux_en_o),     32'd0);
    chk({p, "_ack"},   32'(req_ack_o),    32'd0);
    chk({p, "_rv"},    32'(resp_valid_o), 32'd0);
    chk({p, "_rd"},    32'(resp_data_o),  32'd0);
    chk({p, "_gid"},   32'(grant_id_o),   32'd0);
    chk({p, "_busy"},  32'(busy_o),       32'd0);
    chk({p, "_tmo"},   32'(timeout_o),    32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_o && n < 60) begin tick(); n++; end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT issues or responds.
  always @(negedge fpga_clk_i) begin
    if (mux_en_o) begin
      issues_seen++;
      chk("en_while_busy", 32'(prev_busy), 32'd0);
      chk("ack_vs_grant", 32'(req_ack_o), 32'd1 << grant_id_o);
      chk("issue_expected", 32'(issue_q.size() != 0), 32'd1);
      if (issue_q.size() != 0) begin
        mon_iss = issue_q.pop_front();
        chk("issue_grant", 32'(grant_id_o), 32'(mon_iss.g));
        chk("issue_ins",   32'(mux_ins_o),  32'(mon_iss.ins));
      end
    end
    if (resp_valid_o != '0) begin
      chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
      if (resp_q.size() != 0) begin
        mon_rsp = resp_q.pop_front();
        chk("resp_valid", 32'(resp_valid_o), 32'(mon_rsp.v));
        chk("resp_data",  32'(resp_data_o),  32'(mon_rsp.d));
      end
    end
    if (timeout_o) tmo_seen++;
    prev_busy = busy_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, gap, busy_cnt;
    reset_n_i = 1'b0; req_valid_i = '0; ins0 = '0; ins1 = '0;
    use_model = 1'b0; idle_drv = 1'b1; mux_data_ready_i = 1'b0; mux_data_i = '0;

    // Reset and single request
    repeat (3) tick();
    chk_zero("reset");
    reset_n_i = 1'b1; req_valid_i = 2'b01; ins0 = 24'hABC000;
    issue_q.push_back('{g: 2'd0, ins: 24'hABC000});
    tick();
    chk("single_en",   32'(mux_en_o),  32'd1);
    chk("single_ack",  32'(req_ack_o), 32'b01);
    chk("single_ins",  32'(mux_ins_o), 32'hABC000);
    chk("single_busy", 32'(busy_o),    32'd1);
    req_valid_i = 2'b00;
    tick();
    chk("single_en_pulse",  32'(mux_en_o),  32'd0);
    chk("single_ack_pulse", 32'(req_ack_o), 32'd0);
    wait_idle("single_idle");

    // Round-robin from a fresh reset: 0,1,0,1
    reset_n_i = 1'b0; tick(); tick(); reset_n_i = 1'b1;
    use_model = 1'b1; req_valid_i = 2'b11; ins0 = 24'h111111; ins1 = 24'h222222;
    issue_q.push_back('{g: 2'd0, ins: 24'h111111});
    issue_q.push_back('{g: 2'd1, ins: 24'h222222});
    issue_q.push_back('{g: 2'd0, ins: 24'h111111});
    issue_q.push_back('{g: 2'd1, ins: 24'h222222});
    base = issues_seen; n = 0;
    while (issues_seen < base + 4 && n < 100) begin tick(); n++; end
    chk("rr_count", 32'(issues_seen - base), 32'd4);
    req_valid_i = 2'b00;
    wait_idle("rr_idle");
    use_model = 1'b0; idle_drv = 1'b1;

    // Response routing to requester 1 (last=1, only 1 pending)
    req_valid_i = 2'b10; ins1 = 24'h333333;
    issue_q.push_back('{g: 2'd1, ins: 24'h333333});
    tick();
    chk("rsp_ack", 32'(req_ack_o), 32'b10);
    req_valid_i = 2'b00; idle_drv = 1'b0;
    repeat (4) tick();
    chk("rsp_wait_busy", 32'(busy_o), 32'd1);
    mux_data_ready_i = 1'b1; mux_data_i = 16'h1234;
    resp_q.push_back('{v: 2'b10, d: 16'h1234});
    tick();
    chk("rsp_valid", 32'(resp_valid_o), 32'b10);
    chk("rsp_data",  32'(resp_data_o),  32'h1234);
    mux_data_i = 16'hBEEF;
    resp_q.push_back('{v: 2'b10, d: 16'hBEEF});
    tick();
    chk("rsp_beat2", 32'(resp_data_o), 32'hBEEF);
    mux_data_ready_i = 1'b0;
    tick();
    chk("rsp_pulse", 32'(resp_valid_o), 32'd0);
    idle_drv = 1'b1; mux_data_ready_i = 1'b1; mux_data_i = 16'h5555;
    resp_q.push_back('{v: 2'b10, d: 16'h5555});
    tick();
    chk("rsp_last_busy",  32'(busy_o),       32'd0);
    chk("rsp_last_valid", 32'(resp_valid_o), 32'b10);
    mux_data_i = 16'hDEAD;
    tick();
    chk("stray_valid", 32'(resp_valid_o), 32'd0);
    chk("stray_hold",  32'(resp_data_o),  32'h5555);
    mux_data_ready_i = 1'b0;

    // Guard window: idle held high, request held
    req_valid_i = 2'b01; ins0 = 24'h444444;
    issue_q.push_back('{g: 2'd0, ins: 24'h444444});
    issue_q.push_back('{g: 2'd0, ins: 24'h444444});
    tick();
    chk("guard_en", 32'(mux_en_o), 32'd1);
    busy_cnt = 1; gap = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (mux_en_o) begin gap = k; break; end
      else if (busy_o) busy_cnt++;
    end
    chk("guard_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("guard_issue_gap",   32'(gap),      32'd6);
    req_valid_i = 2'b00;
    wait_idle("guard_idle");

    // Reset mid-operation in WAIT; in-flight data discarded
    req_valid_i = 2'b01; ins0 = 24'h555555;
    issue_q.push_back('{g: 2'd0, ins: 24'h555555});
    tick();
    chk("mid_ack", 32'(req_ack_o), 32'b01);
    req_valid_i = 2'b00; idle_drv = 1'b0;
    repeat (4) tick();
    chk("mid_wait_busy", 32'(busy_o), 32'd1);
    reset_n_i = 1'b0; mux_data_ready_i = 1'b1; mux_data_i = 16'h7777;
    tick();
    chk_zero("mid_rst");
    mux_data_ready_i = 1'b0; reset_n_i = 1'b1; idle_drv = 1'b1;
    req_valid_i = 2'b11; ins1 = 24'h666666;
    issue_q.push_back('{g: 2'd0, ins: 24'h555555});
    tick();
    chk("post_rst_ack", 32'(req_ack_o),  32'b01);
    chk("post_rst_gid", 32'(grant_id_o), 32'd0);
    req_valid_i = 2'b00;
    wait_idle("post_rst_idle");

`ifdef MUX_ARB_TIMEOUT_EN
    // Watchdog: MUX never returns to idle
    req_valid_i = 2'b01; ins0 = 24'h777777;
    issue_q.push_back('{g: 2'd0, ins: 24'h777777});
    tick();
    req_valid_i = 2'b10; ins1 = 24'h888888; idle_drv = 1'b0;
    n = 0;
    while (!timeout_o && n < 40) begin tick(); n++; end
    chk("tmo_pulse", 32'(timeout_o), 32'd1);
    chk("tmo_busy",  32'(busy_o),    32'd0);
    tick();
    chk("tmo_once", 32'(timeout_o), 32'd0);
    tick();
    chk("tmo_no_grant", 32'(req_ack_o), 32'd0);
    idle_drv = 1'b1;
    issue_q.push_back('{g: 2'd1, ins: 24'h888888});
    tick();
    chk("tmo_next_ack", 32'(req_ack_o), 32'b10);
    req_valid_i = 2'b00;
    wait_idle("tmo_idle");
    chk("tmo_count", 32'(tmo_seen), 32'd1);
`else
    chk("tmo_count", 32'(tmo_seen), 32'd0);
`endif

    repeat (2) tick();
    chk("issue_q_empty", 32'(issue_q.size()), 32'd0);
    chk("resp_q_empty",  32'(resp_q.size()),  32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
